contadores_capa: RTL and testbench
==================================

# contadores_capa

Word-counter block for the transaction layer: counts the words drained from the four output ("blue") FIFOs and answers counter-read requests over the req/idx interface. It is the responder side of the counter-read handshake and sits beside the output FIFOs. It observes their pop and empty lines and returns one counter value per request on salida_contador/valid_contador. Reads are honoured only while the layer FSM reports idle.

## Interface
- NUM_FIFOS, 4, number of output FIFOs counted (counters 0..NUM_FIFOS-1)
- CNT_W, 5, width of every counter and of salida_contador
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- Enable  input  1  block enable; low freezes counters and aborts reads
- pop_fifo_azules  input  NUM_FIFOS  pop strobe per output FIFO
- empty_fifo_azules  input  NUM_FIFOS  empty flag per output FIFO
- idle  input  1  layer FSM in IDLE; reads are accepted only when high
- req  input  1  read request, level, initiator holds until valid seen
- idx  input  3  counter select: 0..3 per-FIFO, 4 total
- salida_contador  output  CNT_W  registered counter value
- valid_contador  output  1  one-cycle strobe qualifying salida_contador

## Operation
- Effective pop: pop_fifo_azules[i] & ~empty_fifo_azules[i] & Enable. A pop on an empty FIFO is not counted.
- cnt[i] (i=0..3) += 1 per effective pop. cnt[4] += popcount of the effective pops (0..4) in the same cycle.
- All counters wrap modulo 2^CNT_W (31+1 -> 0). Invariant at every edge: cnt[4] == (cnt[0]+cnt[1]+cnt[2]+cnt[3]) mod 32.
- Read FSM states: ESPERA, LECTURA, RETENER.
  - ESPERA: if req & idle & Enable & idx<=4, capture cnt[idx] into salida_contador and go to LECTURA. If req & idle & idx>4, go to RETENER with no strobe. Otherwise stay.
  - LECTURA: valid_contador=1 for this cycle only. Go to RETENER if req still high, else ESPERA.
  - RETENER: wait for req low, then go to ESPERA. Exactly one response per req assertion.
- Enable low: counters hold, FSM forced to ESPERA, valid_contador=0. salida_contador holds its last value.
- idle low while req is pending in ESPERA: request waits, no strobe, until idle rises.

## Timing
- Reset values: all counters 0, FSM ESPERA, salida_contador=0, valid_contador=0.
- Counting: an effective pop sampled at edge N is visible in the counter after edge N.
- Read latency: req/idx/idle sampled high at edge N; salida_contador and valid_contador are high after edge N, for exactly one cycle.
- Snapshot value is cnt[idx] as registered before edge N. Pops sampled at edge N are excluded from that read and included in the next.
- idx changes while in LECTURA/RETENER are ignored.
- Reset asserted mid-read: valid_contador drops immediately (asynchronously), and the FSM returns to ESPERA.
- All four FIFOs popping in one cycle: cnt[4] += 4 in that single edge, with wrap applied.

## Structure
- Shared package (capa_pkg): CNT_W, NUM_FIFOS, IDX_TOTAL=4, and the FSM state encoding (ESPERA=0, LECTURA=1, RETENER=2), reused by the testbench.
- One natural sub-module: contador_fifo, a single CNT_W wrapping counter with an increment-amount input. Instantiate five of them: four with increment 0/1, one with increment 0..4.
- The read FSM and output mux stay in the top level.

## Test plan
- Reset release: hold reset=0 for 2 cycles with pops active -> all outputs 0. After release, a read of idx 0..4 returns 0.
- Drain: 6 pops on FIFO0, 5 on FIFO1, 4 on FIFO2, 3 on FIFO3 (non-empty), then idle=1 and read idx 0..4 -> 6, 5, 4, 3, 18, each with a single valid pulse one cycle after req.
- Empty guard: pop FIFO2 three times with empty=1 -> cnt[2] and cnt[4] unchanged.
- Simultaneous and wrap: preload cnt[4]=30 (via pops), then pop all four in one cycle -> cnt[4]=2 and invariant holds. Pop FIFO0 32 times -> cnt[0] returns to its start value.
- Handshake rules:
  - req held 5 cycles -> exactly one valid.
  - req with idle=0 -> no valid until idle=1.
  - idx=6 -> no valid, and the next req is served normally.
  - Pop on the request edge is excluded from that read and included in the next.
- Enable low mid-read: drop Enable in LECTURA -> valid=0 next cycle, counters frozen under pops. Re-enable and read -> values unchanged.

Source files
------------

// File: rtl/capa_pkg.sv
// Purpose : shared constants, counter type and read-FSM encoding for the word-counter block.
// Latency : n/a (declarations only).
// Backpress: n/a.
package capa_pkg;

  localparam int NUM_FIFOS = 4;               // output FIFOs counted
  localparam int CNT_W     = 5;               // width of every counter and of salida_contador
  localparam int IDX_W     = 3;               // width of the counter-select field
  localparam int IDX_TOTAL = 4;               // idx value that selects the grand total

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    LECTURA = 2'd1,
    RETENER = 2'd2
  } estado_t;

  // Indices 0..IDX_TOTAL address a real counter; anything above is a bad select.
  function automatic logic idx_valido(input logic [IDX_W-1:0] i);
    return i <= IDX_W'(IDX_TOTAL);
  endfunction

endpackage

// File: rtl/contadores_capa_if.sv
// Purpose : bundles the FIFO observation lines and the counter-read handshake.
// Latency : n/a (wiring only).
// Backpress: req is a level held by the initiator until valid_contador is seen.
// Ports   : Enable, pop/empty per FIFO, idle, req, idx in; salida_contador, valid_contador out.
interface contadores_capa_if;
  import capa_pkg::*;

  logic                 Enable;
  logic [NUM_FIFOS-1:0] pop_fifo_azules;
  logic [NUM_FIFOS-1:0] empty_fifo_azules;
  logic                 idle;
  logic                 req;
  logic [IDX_W-1:0]     idx;
  cnt_t                 salida_contador;
  logic                 valid_contador;

  // Initiator / environment side.
  modport master (
    output Enable, pop_fifo_azules, empty_fifo_azules, idle, req, idx,
    input  salida_contador, valid_contador
  );

  // Counter block side.
  modport slave (
    input  Enable, pop_fifo_azules, empty_fifo_azules, idle, req, idx,
    output salida_contador, valid_contador
  );

endinterface

// File: rtl/contadores_capa_contador_fifo.sv
// Purpose : single CNT_W-bit counter that adds a variable increment each cycle, wrapping.
// Latency : increment sampled at edge N is visible after edge N.
// Backpress: none; an increment of zero holds the value.
// Ports   : clk, reset (async active-low), inc (amount to add), cnt (registered value).
module contador_fifo
  import capa_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  cnt_t inc,
  output cnt_t cnt
);

  // Truncating add gives the modulo-2^CNT_W wrap for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + inc;
  end

endmodule

// File: rtl/contadores_capa.sv
// Purpose : counts words drained from the output FIFOs and answers counter-read requests.
// Latency : read sampled at edge N -> salida_contador/valid_contador after edge N (1 cycle).
// Backpress: one response per req assertion; waits while idle is low; Enable low aborts.
// Ports   : clk, reset (async active-low), bus (slave side of contadores_capa_if).
module contadores_capa
  import capa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  contadores_capa_if.slave   bus
);

  logic [NUM_FIFOS-1:0] pop_ef;
  cnt_t                 inc_fifo [NUM_FIFOS];
  cnt_t                 inc_total;
  cnt_t                 cnt_q    [IDX_TOTAL+1];
  cnt_t                 cnt_sel;
  cnt_t                 salida_q;
  estado_t              estado_q, estado_d;
  logic                 captura;

  // A pop on an empty FIFO moves no data, and Enable low freezes everything.
  assign pop_ef = bus.pop_fifo_azules & ~bus.empty_fifo_azules & {NUM_FIFOS{bus.Enable}};

  always_comb begin
    inc_total = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      inc_fifo[i] = cnt_t'(pop_ef[i]);
      inc_total   = inc_total + cnt_t'(pop_ef[i]);
    end
  end

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_cnt
    contador_fifo u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_fifo[g]),
      .cnt   (cnt_q[g])
    );
  end

  // Total is its own counter fed by the popcount, so it wraps the same way the sum does.
  contador_fifo u_cnt_total (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_total),
    .cnt   (cnt_q[IDX_TOTAL])
  );

  // Snapshot mux reads the registered counters, so a pop on the request edge
  // lands in the next read, not this one.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i <= IDX_TOTAL; i++) begin
      if (bus.idx == IDX_W'(i)) cnt_sel = cnt_q[i];
    end
  end

  always_comb begin
    estado_d = estado_q;
    captura  = 1'b0;
    if (!bus.Enable) begin
      estado_d = ESPERA;
    end else begin
      case (estado_q)
        ESPERA: begin
          if (bus.req && bus.idle) begin
            if (idx_valido(bus.idx)) begin
              captura  = 1'b1;
              estado_d = LECTURA;
            end else begin
              // Bad select: swallow this request silently until req drops.
              estado_d = RETENER;
            end
          end
        end
        LECTURA: estado_d = bus.req ? RETENER : ESPERA;
        RETENER: if (!bus.req) estado_d = ESPERA;
        default: estado_d = ESPERA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado_q <= ESPERA;
    else        estado_q <= estado_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       salida_q <= '0;
    else if (captura) salida_q <= cnt_sel;
  end

  // Decoding valid from the state register makes it drop the instant reset asserts.
  assign bus.valid_contador  = (estado_q == LECTURA);
  assign bus.salida_contador = salida_q;

endmodule

// File: tb/tb_contadores_capa.sv
// Purpose : self-checking bench for contadores_capa with a reference model and response scoreboard.
// Latency : expects the response one edge after the request edge.
// Backpress: holds req until the response, as the real initiator does.
module tb_contadores_capa;
  import capa_pkg::*;

  logic clk;
  logic reset;
  contadores_capa_if bus ();

  contadores_capa dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks  = 0;
  int   errors  = 0;
  int   vld_cnt = 0;
  cnt_t mdl [IDX_TOTAL+1];
  cnt_t exp_q [$];
  cnt_t exp_v;

  // Scoreboard consumer: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.valid_contador === 1'b1) begin
      vld_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: salida=%0d with no read outstanding", bus.salida_contador);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.salida_contador !== exp_v) begin
          errors++;
          $display("FAIL read_value: got %0d expected %0d", bus.salida_contador, exp_v);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i <= IDX_TOTAL; i++) mdl[i] = '0;
  endtask

  task automatic model_pop(input logic [3:0] p, input logic [3:0] e);
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (p[i] && !e[i] && bus.Enable) begin
        mdl[i]         = mdl[i] + 5'd1;
        mdl[IDX_TOTAL] = mdl[IDX_TOTAL] + 5'd1;
      end
    end
  endtask

  // Called at a falling edge; applies pops for exactly one rising edge.
  task automatic pop_cycle(input logic [3:0] p, input logic [3:0] e);
    bus.pop_fifo_azules   = p;
    bus.empty_fifo_azules = e;
    model_pop(p, e);
    @(negedge clk);
    bus.pop_fifo_azules   = '0;
    bus.empty_fifo_azules = '0;
  endtask

  // Read one counter holding req for 'hold' cycles; optional pops on the request edge.
  task automatic rd(input logic [2:0] i, input int hold, input logic [3:0] p);
    int base;
    bus.req = 1'b1;
    bus.idx = i;
    exp_q.push_back(mdl[i]);
    base = vld_cnt;
    bus.pop_fifo_azules   = p;
    bus.empty_fifo_azules = '0;
    model_pop(p, 4'b0000);
    @(posedge clk); #1;
    checks++;
    if (bus.valid_contador !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency idx=%0d: valid=%b expected 1", i, bus.valid_contador);
    end
    @(negedge clk);
    bus.pop_fifo_azules = '0;
    repeat (hold - 1) @(negedge clk);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (vld_cnt - base != 1) begin
      errors++;
      $display("FAIL rd_pulses idx=%0d hold=%0d: got %0d pulses expected 1", i, hold, vld_cnt - base);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Enable = 1'b1;
    bus.idle = 1'b1;
    bus.req = 1'b0;
    bus.idx = '0;
    bus.pop_fifo_azules = 4'hF;
    bus.empty_fifo_azules = 4'h0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.salida_contador !== 5'd0 || bus.valid_contador !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: salida=%0d valid=%b expected 0/0", bus.salida_contador, bus.valid_contador);
    end
    bus.pop_fifo_azules = '0;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= IDX_TOTAL; i++) rd(3'(i), 1, 4'b0000);
  endtask

  task automatic test_drain();
    for (int k = 0; k < 6; k++) pop_cycle({k < 3, k < 4, k < 5, 1'b1}, 4'b0000);
    for (int i = 0; i <= IDX_TOTAL; i++) rd(3'(i), 1, 4'b0000);
  endtask

  task automatic test_empty_guard();
    repeat (3) pop_cycle(4'b0100, 4'b0100);
    rd(3'd2, 1, 4'b0000);
    rd(3'd4, 1, 4'b0000);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 40; k++) begin
      if (mdl[IDX_TOTAL] == 5'd30) break;
      pop_cycle(4'b0010, 4'b0000);
    end
    pop_cycle(4'b1111, 4'b0000);
    for (int i = 0; i <= IDX_TOTAL; i++) rd(3'(i), 1, 4'b0000);
    repeat (32) pop_cycle(4'b0001, 4'b0000);
    rd(3'd0, 1, 4'b0000);
    rd(3'd4, 1, 4'b0000);
  endtask

  task automatic test_handshake();
    int base;
    // Long hold yields a single pulse.
    rd(3'd1, 5, 4'b0000);
    // idle low parks the request.
    bus.idle = 1'b0;
    bus.req  = 1'b1;
    bus.idx  = 3'd1;
    base = vld_cnt;
    repeat (4) @(negedge clk);
    checks++;
    if (vld_cnt != base) begin
      errors++;
      $display("FAIL idle_block: got %0d pulses expected 0", vld_cnt - base);
    end
    exp_q.push_back(mdl[1]);
    bus.idle = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.valid_contador !== 1'b1) begin
      errors++;
      $display("FAIL idle_release: valid=%b expected 1", bus.valid_contador);
    end
    @(negedge clk);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (vld_cnt != base + 1) begin
      errors++;
      $display("FAIL idle_pulses: got %0d expected 1", vld_cnt - base);
    end
    // Bad select is swallowed, next request is normal.
    bus.req = 1'b1;
    bus.idx = 3'd6;
    base = vld_cnt;
    repeat (4) @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (vld_cnt != base) begin
      errors++;
      $display("FAIL bad_idx: got %0d pulses expected 0", vld_cnt - base);
    end
    rd(3'd2, 1, 4'b0000);
    // Pop on the request edge goes to the following read.
    rd(3'd0, 1, 4'b0001);
    rd(3'd0, 1, 4'b0000);
    rd(3'd4, 1, 4'b0000);
  endtask

  task automatic test_enable();
    cnt_t snap;
    bus.req = 1'b1;
    bus.idx = 3'd3;
    snap = mdl[3];
    exp_q.push_back(snap);
    @(posedge clk); #1;
    checks++;
    if (bus.valid_contador !== 1'b1) begin
      errors++;
      $display("FAIL en_read_start: valid=%b expected 1", bus.valid_contador);
    end
    @(negedge clk);
    bus.Enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.valid_contador !== 1'b0 || bus.salida_contador !== snap) begin
      errors++;
      $display("FAIL en_abort: valid=%b salida=%0d expected 0/%0d", bus.valid_contador, bus.salida_contador, snap);
    end
    @(negedge clk);
    repeat (3) pop_cycle(4'b1111, 4'b0000);
    bus.req = 1'b0;
    bus.Enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= IDX_TOTAL; i++) rd(3'(i), 1, 4'b0000);
  endtask

  task automatic test_reset_mid_read();
    bus.req = 1'b1;
    bus.idx = 3'd4;
    exp_q.push_back(mdl[4]);
    @(posedge clk); #1;
    checks++;
    if (bus.valid_contador !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_start: valid=%b expected 1", bus.valid_contador);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.valid_contador !== 1'b0 || bus.salida_contador !== 5'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b salida=%0d expected 0/0", bus.valid_contador, bus.salida_contador);
    end
    void'(exp_q.pop_back());
    model_clear();
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(3'd4, 1, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_drain();
    test_empty_guard();
    test_wrap();
    test_handshake();
    test_enable();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads never answered, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
